// File: rtl/multdiv_sequencer_pkg.sv
// rtl/multdiv_sequencer_pkg.sv - shared encodings and register/rstatus constants for the mult/div sequencer
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // rstatus codes are shared with the ALU-exception path
    localparam int REG_RSTATUS = 30;
    localparam int RSTATUS_MUL = 4;
    localparam int RSTATUS_DIV = 5;

endpackage

// File: rtl/multdiv_sequencer_sat_counter.sv
// rtl/multdiv_sequencer_sat_counter.sv - saturating up-counter with sync clear and terminal-count flag
module multdiv_sequencer_sat_counter #(
    parameter int MAX = 64,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the enabled cycle that brings the count up to MAX.
    assign tc_o = en_i && (count_q == W'(MAX - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - X-stage sequencer: launches mult/div, stalls the pipe, emits one writeback
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_valid,
    input  logic              mult_signal,
    input  logic              div_signal,
    input  logic [REG_W-1:0]  x_rd,
    input  logic              data_resultRDY,
    input  logic [DATA_W-1:0] data_result,
    input  logic              data_exception,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              timeout_err
);

    state_e              state_q, state_d;
    logic                op_mult_q, op_mult_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic                ctrl_mult_q, ctrl_mult_d;
    logic                ctrl_div_q, ctrl_div_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                timeout_q, timeout_d;
    logic                cnt_clear, cnt_en, cnt_tc;

    multdiv_sequencer_sat_counter #(.MAX(TIMEOUT)) u_run_counter (
        .clock   (clock),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        op_mult_d   = op_mult_q;
        rd_d        = rd_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = '0;
        wb_data_d   = '0;
        timeout_d   = timeout_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        stall       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (x_valid && (mult_signal || div_signal)) begin
                    stall       = 1'b1;
                    op_mult_d   = mult_signal;
                    rd_d        = x_rd;
                    ctrl_mult_d = mult_signal;
                    ctrl_div_d  = !mult_signal;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                stall     = 1'b1;
                cnt_clear = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                // A result arriving on the last allowed cycle still wins over the abort.
                if (data_resultRDY) begin
                    state_d = S_DONE;
                    if (data_exception) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = REG_W'(REG_RSTATUS);
                        wb_data_d  = op_mult_q ? DATA_W'(RSTATUS_MUL) : DATA_W'(RSTATUS_DIV);
                    end else if (rd_q != '0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = data_result;
                    end
                end else if (cnt_tc) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_mult_q   <= 1'b0;
            rd_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_mult_q   <= op_mult_d;
            rd_q        <= rd_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ctrl_MULT   = ctrl_mult_q;
    assign ctrl_DIV    = ctrl_div_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        x_valid;
    logic        mult_signal;
    logic        div_signal;
    logic [4:0]  x_rd;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        data_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        timeout_err;

    multdiv_sequencer #(.DATA_W(32), .REG_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .x_valid        (x_valid),
        .mult_signal    (mult_signal),
        .div_signal     (div_signal),
        .x_rd           (x_rd),
        .data_resultRDY (data_resultRDY),
        .data_result    (data_result),
        .data_exception (data_exception),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        d;
        logic [4:0]  rd;
        int          lat;
        logic [31:0] res;
        logic        exc;
        int          exp_m;
        int          exp_d;
        int          exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_mult = 0, n_div = 0, n_stall = 0, n_wb = 0;
    int last_mult_cyc = -1, last_div_cyc = -1, last_wb_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (ctrl_MULT) begin n_mult++; last_mult_cyc = cyc; end
        if (ctrl_DIV)  begin n_div++;  last_div_cyc  = cyc; end
        if (stall) n_stall++;
        if (ctrl_MULT || ctrl_DIV) check("ctrl_exclusive", 64'(ctrl_MULT & ctrl_DIV), 64'd0);
        if (!wb_valid) begin
            check("wb_idle_zero", 64'({wb_rd, wb_data}), 64'd0);
        end else begin
            n_wb++;
            last_wb_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb actual rd=%0d data=%0h required none", wb_rd, wb_data);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input vec_t v);
        int m0, d0, s0, w0, acc, rdyc;
        m0 = n_mult; d0 = n_div; s0 = n_stall; w0 = n_wb;
        tick();
        x_valid = 1'b1; mult_signal = v.m; div_signal = v.d; x_rd = v.rd;
        acc = cyc;
        tick();
        mult_signal = ~v.m; div_signal = ~v.d; x_rd = ~v.rd;
        tick();
        x_valid = 1'b0; mult_signal = 1'b0; div_signal = 1'b0; x_rd = 5'd0;
        for (int i = 1; i < v.lat; i++) tick();
        if (v.exp_wb != 0) sb.push_back('{v.exp_rd, v.exp_data});
        data_resultRDY = 1'b1; data_result = v.res; data_exception = v.exc;
        rdyc = cyc;
        tick();
        data_resultRDY = 1'b0; data_result = 32'd0; data_exception = 1'b0;
        tick();
        check("op_mult_pulses", 64'(n_mult - m0), 64'(v.exp_m));
        check("op_div_pulses", 64'(n_div - d0), 64'(v.exp_d));
        if (v.exp_m != 0) check("op_pulse_cycle", 64'(last_mult_cyc), 64'(acc + 1));
        if (v.exp_d != 0) check("op_pulse_cycle", 64'(last_div_cyc), 64'(acc + 1));
        check("op_stall_cycles", 64'(n_stall - s0), 64'(v.lat + 2));
        check("op_wb_count", 64'(n_wb - w0), 64'(v.exp_wb));
        if (v.exp_wb != 0) check("op_wb_cycle", 64'(last_wb_cyc), 64'(rdyc + 1));
        check("op_idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, n, dcyc, m0;
        vecs[0] = '{1'b1, 1'b0, 5'd3,  17, 32'd42,        1'b0, 1, 0, 1, 5'd3,  32'd42};
        vecs[1] = '{1'b0, 1'b1, 5'd7,  5,  32'd123,       1'b1, 0, 1, 1, 5'd30, 32'd5};
        vecs[2] = '{1'b1, 1'b0, 5'd7,  3,  32'd99,        1'b1, 1, 0, 1, 5'd30, 32'd4};
        vecs[3] = '{1'b1, 1'b0, 5'd0,  4,  32'd9,         1'b0, 1, 0, 0, 5'd0,  32'd0};
        vecs[4] = '{1'b1, 1'b1, 5'd9,  2,  32'd77,        1'b0, 1, 0, 1, 5'd9,  32'd77};
        vecs[5] = '{1'b0, 1'b1, 5'd31, 1,  32'hdeadbeef,  1'b0, 0, 1, 1, 5'd31, 32'hdeadbeef};
        vecs[6] = '{1'b0, 1'b1, 5'd12, TIMEOUT, 32'h1234, 1'b0, 0, 1, 1, 5'd12, 32'h1234};

        reset = 1'b1; x_valid = 1'b0; mult_signal = 1'b0; div_signal = 1'b0; x_rd = 5'd0;
        data_resultRDY = 1'b0; data_result = 32'd0; data_exception = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("reset_outputs", 64'({ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_rd, wb_data, busy, timeout_err}), 64'd0);

        // spurious result in IDLE
        tick();
        data_resultRDY = 1'b1; data_result = 32'd55;
        @(negedge clock);
        check("spurious_busy", 64'(busy), 64'd0);
        check("spurious_stall", 64'(stall), 64'd0);
        tick();
        data_resultRDY = 1'b0; data_result = 32'd0;
        @(negedge clock);
        check("spurious_state", 64'({busy, wb_valid}), 64'd0);

        for (int i = 0; i < 7; i++) do_op(vecs[i]);

        // timeout: result never arrives
        s0 = n_stall; w0 = n_wb;
        tick();
        x_valid = 1'b1; div_signal = 1'b1; x_rd = 5'd8;
        tick();
        x_valid = 1'b0; div_signal = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("timeout_bounded", 64'(n < 200), 64'd1);
        check("timeout_stall_cycles", 64'(n_stall - s0), 64'(TIMEOUT + 2));
        check("timeout_err_set", 64'(timeout_err), 64'd1);
        check("timeout_no_wb", 64'(n_wb - w0), 64'd0);
        @(negedge clock);
        check("timeout_stall_released", 64'(stall), 64'd0);
        do_op(vecs[0]);
        check("timeout_err_sticky", 64'(timeout_err), 64'd1);

        // reset in the middle of RUN, result arrives right after
        m0 = n_mult; w0 = n_wb;
        tick();
        x_valid = 1'b1; mult_signal = 1'b1; x_rd = 5'd5;
        tick();
        x_valid = 1'b0; mult_signal = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; data_resultRDY = 1'b1; data_result = 32'd5;
        @(negedge clock);
        check("midreset_state", 64'({busy, stall, wb_valid, timeout_err}), 64'd0);
        tick();
        data_resultRDY = 1'b0; data_result = 32'd0;
        @(negedge clock);
        check("midreset_after", 64'({busy, wb_valid}), 64'd0);
        check("midreset_no_wb", 64'(n_wb - w0), 64'd0);
        check("midreset_pulses", 64'(n_mult - m0), 64'd1);

        // back-to-back: second mul presented during DONE
        m0 = n_mult;
        tick();
        x_valid = 1'b1; mult_signal = 1'b1; x_rd = 5'd4;
        tick();
        x_valid = 1'b0; mult_signal = 1'b0;
        tick();
        tick();
        sb.push_back('{5'd4, 32'd11});
        data_resultRDY = 1'b1; data_result = 32'd11;
        tick();
        data_resultRDY = 1'b0; data_result = 32'd0;
        x_valid = 1'b1; mult_signal = 1'b1; x_rd = 5'd6;
        dcyc = cyc;
        @(negedge clock);
        check("b2b_done_no_stall", 64'(stall), 64'd0);
        tick();
        tick();
        x_valid = 1'b0; mult_signal = 1'b0; x_rd = 5'd0;
        tick();
        check("b2b_first_wb_cycle", 64'(last_wb_cyc), 64'(dcyc));
        check("b2b_second_pulse", 64'(last_mult_cyc), 64'(dcyc + 2));
        check("b2b_pulse_count", 64'(n_mult - m0), 64'd2);
        sb.push_back('{5'd6, 32'd22});
        data_resultRDY = 1'b1; data_result = 32'd22;
        tick();
        data_resultRDY = 1'b0; data_result = 32'd0;
        tick();
        check("b2b_idle", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
